// File: rtl/demux_pkg.sv
// Shared definitions for the demux_scan block.
//   MODE_DIRECT / MODE_SCAN : encoding of the mode input
//   state_e                 : state of the direct/scan mode FSM
//   clog2_min1              : ceil(log2(value)), never less than 1 bit
package demux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    DIRECT = 1'b0,
    SCAN   = 1'b1
  } state_e;

  // Gives a usable counter width even when value is 1.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter plus output index for the scan mode of demux_scan.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : treat the stored count and index as zero this cycle
//                 (used on entry into scan)
//   advance_en  : count one dwell cycle
//   index       : index to drive this cycle (already zero while clear is high)
//   wrap        : high for one cycle after the index stepped N_OUT-1 -> 0
module scan_counter
  import demux_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance_en,
  output logic [SEL_W-1:0] index,
  output logic             wrap
);

  localparam int              CNT_W    = clog2_min1(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic [SEL_W-1:0] idx_q, idx_d, idx_cur;
  logic             wrap_q, wrap_d;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_cur = clear ? '0 : cnt_q;
    idx_cur = clear ? '0 : idx_q;
    cnt_d   = cnt_cur;
    idx_d   = idx_cur;
    wrap_d  = 1'b0;
    if (advance_en) begin
      if (cnt_cur == CNT_LAST) begin
        cnt_d  = '0;
        // Index width is exactly SEL_W, so N_OUT-1 rolls over to 0 by itself.
        idx_d  = idx_cur + SEL_W'(1);
        wrap_d = &idx_cur;
      end else begin
        cnt_d = cnt_cur + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign index = idx_cur;
  assign wrap  = wrap_q;

endmodule

// File: rtl/demux_scan.sv
// Registered 1-to-N demultiplexer with enable and auto-scan mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : DATA_W data routed to the selected slice
//   sel        : slice index in direct mode (ignored in scan mode)
//   mode       : 0 = direct, 1 = scan
//   en         : routing / scan-advance enable
//   out        : N_OUT slices, slice k = out[k*DATA_W +: DATA_W]
//   out_valid  : out carries routed data
//   cur_sel    : index currently driven (holds while disabled)
//   wrap       : one-cycle pulse when the scan returns to slice 0
module demux_scan
  import demux_pkg::*;
#(
  parameter int SEL_W  = 2,
  parameter int DATA_W = 1,
  parameter int DWELL  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_W-1:0]              in,
  input  logic [SEL_W-1:0]               sel,
  input  logic                           mode,
  input  logic                           en,
  output logic [(2**SEL_W)*DATA_W-1:0]   out,
  output logic                           out_valid,
  output logic [SEL_W-1:0]               cur_sel,
  output logic                           wrap
);

  localparam int N_OUT = 2**SEL_W;

  state_e                    state_q, state_d;
  logic                      scan_now, sc_clear, sc_advance, sc_wrap;
  logic [SEL_W-1:0]          sc_index, route_sel;
  logic [N_OUT*DATA_W-1:0]   out_q, out_d;
  logic                      valid_q, valid_d;
  logic [SEL_W-1:0]          cur_sel_q, cur_sel_d;
  logic                      wrap_q, wrap_d;

  // Mode FSM: the state only records whether the previous cycle was scan,
  // so that a fresh entry restarts the scan from slice 0.
  always_comb begin
    scan_now   = (mode == MODE_SCAN);
    state_d    = scan_now ? SCAN : DIRECT;
    sc_clear   = scan_now && (state_q == DIRECT);
    sc_advance = scan_now && en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIRECT;
    else        state_q <= state_d;
  end

  scan_counter #(
    .DWELL (DWELL),
    .SEL_W (SEL_W)
  ) u_scan_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (sc_clear),
    .advance_en (sc_advance),
    .index      (sc_index),
    .wrap       (sc_wrap)
  );

  // Output routing: data follows in every cycle, it is not latched per dwell.
  always_comb begin
    route_sel = scan_now ? sc_index : sel;
    out_d     = '0;
    valid_d   = 1'b0;
    cur_sel_d = cur_sel_q;
    wrap_d    = 1'b0;
    if (en) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (route_sel == SEL_W'(k)) out_d[k*DATA_W +: DATA_W] = in;
      end
      valid_d   = 1'b1;
      cur_sel_d = route_sel;
      wrap_d    = scan_now && sc_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      valid_q   <= 1'b0;
      cur_sel_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      out_q     <= out_d;
      valid_q   <= valid_d;
      cur_sel_q <= cur_sel_d;
      wrap_q    <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cur_sel   = cur_sel_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_demux_scan.sv
// Self-checking bench for demux_scan: one instance with SEL_W=2, DATA_W=1,
// DWELL=4 and one with SEL_W=2, DATA_W=8, DWELL=1.
module tb_demux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in;
  logic [1:0] a_sel;
  logic       a_mode, a_en;
  logic [3:0] a_out;
  logic       a_valid;
  logic [1:0] a_cur;
  logic       a_wrap;

  logic [7:0]  b_in;
  logic [1:0]  b_sel;
  logic        b_mode, b_en;
  logic [31:0] b_out;
  logic        b_valid;
  logic [1:0]  b_cur;
  logic        b_wrap;

  demux_scan #(.SEL_W(2), .DATA_W(1), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .sel(a_sel), .mode(a_mode), .en(a_en),
    .out(a_out), .out_valid(a_valid), .cur_sel(a_cur), .wrap(a_wrap)
  );

  demux_scan #(.SEL_W(2), .DATA_W(8), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .sel(b_sel), .mode(b_mode), .en(b_en),
    .out(b_out), .out_valid(b_valid), .cur_sel(b_cur), .wrap(b_wrap)
  );

  typedef struct {
    logic [31:0] out;
    logic        valid;
    logic [1:0]  cur;
    logic        wrap;
    string       name;
  } exp_t;

  typedef struct {
    logic       din;
    logic [1:0] sel;
    logic       en;
    logic [3:0] out;
    logic       valid;
    logic [1:0] cur;
  } vec_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  vec_t vecs[9];

  int checks   = 0;
  int failures = 0;
  int k;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] o, input logic v, input logic [1:0] c,
                              input logic w, input string nm);
    exp_t x;
    x.out = o; x.valid = v; x.cur = c; x.wrap = w; x.name = nm;
    return x;
  endfunction

  task automatic check_a_now(input string nm, input exp_t x);
    check({nm, ".out"},   {28'd0, a_out},   x.out);
    check({nm, ".valid"}, {31'd0, a_valid}, {31'd0, x.valid});
    check({nm, ".cur"},   {30'd0, a_cur},   {30'd0, x.cur});
    check({nm, ".wrap"},  {31'd0, a_wrap},  {31'd0, x.wrap});
  endtask

  // Drive one cycle on instance A; the expectation waits in the scoreboard
  // until the registered result is visible after the edge.
  task automatic tick_a(input logic din, input logic [1:0] s, input logic m,
                        input logic e, input exp_t x);
    exp_t got;
    @(negedge clk);
    a_in = din; a_sel = s; a_mode = m; a_en = e;
    sb_a.push_back(x);
    @(posedge clk);
    #1;
    got = sb_a.pop_front();
    check_a_now(got.name, got);
  endtask

  task automatic tick_b(input logic [7:0] din, input logic [1:0] s, input logic m,
                        input logic e, input exp_t x);
    exp_t got;
    @(negedge clk);
    b_in = din; b_sel = s; b_mode = m; b_en = e;
    sb_b.push_back(x);
    @(posedge clk);
    #1;
    got = sb_b.pop_front();
    check({got.name, ".out"},   b_out,             got.out);
    check({got.name, ".valid"}, {31'd0, b_valid},  {31'd0, got.valid});
    check({got.name, ".cur"},   {30'd0, b_cur},    {30'd0, got.cur});
    check({got.name, ".wrap"},  {31'd0, b_wrap},   {31'd0, got.wrap});
  endtask

  // k counts enabled scan cycles since scan entry; slice (k/4)%4 is shown and
  // wrap accompanies each return to slice 0 after the first pass.
  task automatic scan_run(input int n, input bit vary);
    for (int i = 0; i < n; i++) begin
      int   idx;
      logic din;
      exp_t x;
      idx = (k / 4) % 4;
      din = (!vary || (k % 3 != 1));
      x = mk(din ? (32'd1 << idx) : 32'd0, 1'b1, 2'(idx), (k > 0 && k % 16 == 0),
             $sformatf("scan_k%0d", k));
      // sel is held at 3 to show it is ignored in scan mode.
      tick_a(din, 2'd3, 1'b1, 1'b1, x);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din:1'b1, sel:2'd2, en:1'b1, out:4'b0100, valid:1'b1, cur:2'd2};
    vecs[1] = '{din:1'b1, sel:2'd0, en:1'b1, out:4'b0001, valid:1'b1, cur:2'd0};
    vecs[2] = '{din:1'b1, sel:2'd1, en:1'b1, out:4'b0010, valid:1'b1, cur:2'd1};
    vecs[3] = '{din:1'b1, sel:2'd2, en:1'b1, out:4'b0100, valid:1'b1, cur:2'd2};
    vecs[4] = '{din:1'b1, sel:2'd3, en:1'b1, out:4'b1000, valid:1'b1, cur:2'd3};
    vecs[5] = '{din:1'b0, sel:2'd3, en:1'b1, out:4'b0000, valid:1'b1, cur:2'd3};
    vecs[6] = '{din:1'b1, sel:2'd1, en:1'b0, out:4'b0000, valid:1'b0, cur:2'd3};
    vecs[7] = '{din:1'b0, sel:2'd0, en:1'b0, out:4'b0000, valid:1'b0, cur:2'd3};
    vecs[8] = '{din:1'b1, sel:2'd0, en:1'b1, out:4'b0001, valid:1'b1, cur:2'd0};

    rst_n = 1'b0;
    a_in = 1'b1; a_sel = 2'd2; a_mode = 1'b0; a_en = 1'b1;
    b_in = 8'hFF; b_sel = 2'd1; b_mode = 1'b0; b_en = 1'b1;

    // Reset held with live inputs: everything stays zero across edges.
    repeat (2) @(posedge clk);
    #1;
    check_a_now("reset_a", mk(32'd0, 1'b0, 2'd0, 1'b0, "reset_a"));
    check("reset_b.out", b_out, 32'd0);
    check("reset_b.valid", {31'd0, b_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b_en = 1'b0;

    // Direct mode table.
    for (int i = 0; i < 9; i++) begin
      tick_a(vecs[i].din, vecs[i].sel, 1'b0, vecs[i].en,
             mk({28'd0, vecs[i].out}, vecs[i].valid, vecs[i].cur, 1'b0,
                $sformatf("direct_%0d", i)));
    end

    // Scan: first full pass plus wrap, then on to the second dwell cycle of index 2.
    k = 0;
    scan_run(26, 1'b0);
    // Freeze for 3 cycles: outputs cleared, cur_sel holds at 2.
    for (int i = 0; i < 3; i++) begin
      tick_a(1'b1, 2'd3, 1'b1, 1'b0, mk(32'd0, 1'b0, 2'd2, 1'b0, $sformatf("freeze_%0d", i)));
    end
    // Resume: index 2 for 2 more cycles, index 3, then the second wrap;
    // data toggles mid-dwell from here on.
    scan_run(7, 1'b0);
    scan_run(13, 1'b1);

    // Leave scan in the middle of index 3, two direct cycles.
    tick_a(1'b1, 2'd1, 1'b0, 1'b1, mk(32'h2, 1'b1, 2'd1, 1'b0, "leave_0"));
    tick_a(1'b1, 2'd3, 1'b0, 1'b1, mk(32'h8, 1'b1, 2'd3, 1'b0, "leave_1"));

    // Re-entry restarts at index 0.
    k = 0;
    scan_run(5, 1'b0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_a_now("async_rst", mk(32'd0, 1'b0, 2'd0, 1'b0, "async_rst"));
    @(posedge clk);
    #1;
    check_a_now("rst_held", mk(32'd0, 1'b0, 2'd0, 1'b0, "rst_held"));
    #1;
    rst_n = 1'b1;
    k = 0;
    scan_run(6, 1'b0);

    // Instance B: DATA_W=8, DWELL=1.
    tick_b(8'h3C, 2'd3, 1'b0, 1'b1, mk(32'h3C00_0000, 1'b1, 2'd3, 1'b0, "b_direct"));
    for (int kb = 0; kb < 10; kb++) begin
      tick_b(8'hA5, 2'd2, 1'b1, 1'b1,
             mk(32'hA5 << (8 * (kb % 4)), 1'b1, 2'(kb % 4), (kb > 0 && kb % 4 == 0),
                $sformatf("b_scan_%0d", kb)));
    end
    tick_b(8'hA5, 2'd2, 1'b1, 1'b0, mk(32'd0, 1'b0, 2'd1, 1'b0, "b_off"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_scan.md
Name: demux_scan

Overview:
- Parametrised, registered 1-to-N demultiplexer. It is the successor to the team's combinational 1-to-4 decoder.
- Adds three things the decoder lacks: a DATA_W-wide data path, an enable, and an auto-scan mode.
- In auto-scan mode the block steps its own select through every output, holding each one for DWELL cycles. It also reports the current index and a wrap pulse.
- Intended uses: digit/row strobing for multiplexed displays, and round-robin fan-out of a bus.

Parameters:
- SEL_W, 2, select width; N_OUT = 2**SEL_W outputs.
- DATA_W, 1, width of the data input and of each output slice.
- DWELL, 4, cycles each output stays selected in scan mode. Must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- in  in  DATA_W  data to route.
- sel  in  SEL_W  output index in direct mode; ignored in scan mode.
- mode  in  1  0 = direct, 1 = scan.
- en  in  1  routing/advance enable.
- out  out  N_OUT*DATA_W  slice k = out[k*DATA_W +: DATA_W].
- out_valid  out  1  out carries routed data.
- cur_sel  out  SEL_W  index currently driven.
- wrap  out  1  one-cycle pulse on scan wrap from N_OUT-1 to 0.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are 0 and held while rst_n is low: out, out_valid, cur_sel, wrap, the internal scan index and the dwell counter.
- All outputs are registered. Latency is 1 cycle from a sampled input to its visible effect.
- Direct mode (mode=0), en=1:
  - next out has slice[sel]=in and every other slice 0.
  - cur_sel<=sel, out_valid<=1, wrap<=0.
- Direct mode, en=0: out<=0, out_valid<=0, cur_sel holds, wrap<=0.
- Scan mode (mode=1): the block runs a two-state FSM with states DIRECT and SCAN, driven by mode.
  - Entering SCAN (mode 0->1 sampled) sets the scan index to 0 and the dwell counter to 0.
  - The first scan cycle drives slice 0.
- In SCAN with en=1:
  - out: slice[index]=in, every other slice 0.
  - cur_sel<=index, out_valid<=1.
  - Dwell counter increments each cycle. When it equals DWELL-1 it returns to 0 and the index advances modulo N_OUT.
- wrap<=1 for exactly the cycle in which the index advances from N_OUT-1 to 0; it is 0 otherwise.
- In SCAN with en=0:
  - Dwell counter and index freeze.
  - out<=0, out_valid<=0, wrap<=0, cur_sel holds.
  - When en returns to 1, counting resumes from the frozen values.
- Leaving SCAN (mode 1->0): direct behaviour applies from that cycle. Scan state is discarded and is re-zeroed on the next entry.
- DWELL=1: the index advances every enabled cycle. wrap pulses once every N_OUT enabled cycles.
- in changing mid-dwell: the output follows in on the selected slice every cycle. Data is not latched per dwell.
- Reset asserted mid-scan: all state clears immediately. After release the FSM is in DIRECT.
- Width rules:
  - Dwell counter is clog2(DWELL) bits, minimum 1.
  - Index is SEL_W bits and wraps naturally, with no explicit compare beyond the wrap detect.

Decomposition:
- Package demux_pkg holds:
  - the mode encoding constants MODE_DIRECT=0 and MODE_SCAN=1;
  - the state typedef (DIRECT, SCAN);
  - a clog2 helper function.
- One sub-module, scan_counter, contains the dwell counter plus index.
  - Parameters: DWELL, SEL_W.
  - Ports: clk, rst_n, clear, advance_en, index, wrap.
  - demux_scan instantiates it and owns the mode FSM and the output registers.

Test Plan:
- Reset: hold rst_n=0 with in=1, en=1 -> out=0000, out_valid=0, cur_sel=00, wrap=0. Release, then sel=10, mode=0 -> one cycle later out=0100, cur_sel=10, out_valid=1.
- Direct sweep (SEL_W=2, DATA_W=1): sel 00,01,10,11 with in=1, then in=0 -> out 0001, 0010, 0100, 1000 one cycle after each, then 0000 with out_valid=1. en=0 -> out=0000, out_valid=0.
- Scan (DWELL=4, in=1): mode=1, en=1 -> out=0001 for 4 cycles, then 0010, 0100, 1000 for 4 cycles each, then 0001 with wrap=1 for exactly that one cycle. Period is 16 cycles.
- Scan freeze: deassert en on the 2nd dwell cycle of index 2 for 3 cycles -> out=0000, out_valid=0, cur_sel=10. After re-enable, index 2 shows for the remaining 2 cycles before advancing to 3.
- Mode toggle and DWELL=1: leave scan mid-index 3, then re-enter -> scan restarts at index 0. With DWELL=1, DATA_W=8 and in=8'hA5 -> slices rotate every cycle and wrap pulses every 4th cycle.
- Asynchronous reset mid-scan: drop rst_n between clock edges -> outputs clear without waiting for a clock edge. After release with mode=1 sampled, scan starts from index 0.
